// File: rtl/bp_table_sequencer.sv
// Sequencer and sole write-port owner for the branch-predictor 2-bit counter table:
// init/flush sweeps plus a two-stage read-modify-write update pipeline with forwarding.
module bp_table_sequencer #(
  parameter int         INDEX_BITS = 8,
  parameter logic [1:0] INIT_VALUE = 2'b10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_req,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  output logic                  upd_ready,
  output logic [INDEX_BITS-1:0] tbl_raddr,
  input  logic [1:0]            tbl_rdata,
  output logic                  tbl_we,
  output logic [INDEX_BITS-1:0] tbl_waddr,
  output logic [1:0]            tbl_wdata,
  output logic                  busy
);

  localparam logic [1:0] S_INIT       = 2'd0;
  localparam logic [1:0] S_RUN        = 2'd1;
  localparam logic [1:0] S_FLUSH_WAIT = 2'd2;
  localparam logic [1:0] S_FLUSH      = 2'd3;

  logic [1:0]            r_state;
  logic [INDEX_BITS-1:0] r_cnt;
  logic                  r_b_valid;
  logic [INDEX_BITS-1:0] r_b_index;
  logic                  r_b_taken;
  logic                  r_fwd_valid;
  logic [INDEX_BITS-1:0] r_fwd_index;
  logic [1:0]            r_fwd_data;

  logic                  w_sweep;
  logic                  w_accept;
  logic [1:0]            w_operand;
  logic [1:0]            w_new;

  assign w_sweep  = (r_state == S_INIT) || (r_state == S_FLUSH);
  assign w_accept = !reset && (r_state == S_RUN) && upd_valid;

  assign upd_ready = !reset && (r_state == S_RUN);
  assign busy      = reset || (r_state != S_RUN);
  assign tbl_raddr = w_accept ? upd_index : '0;

  // The previous stage-B write has not yet landed in tbl_rdata, so it is bypassed here.
  always_comb begin
    w_operand = tbl_rdata;
    if (r_fwd_valid && (r_fwd_index == r_b_index)) w_operand = r_fwd_data;
    if (r_b_taken) w_new = (w_operand == 2'b11) ? 2'b11 : w_operand + 2'b01;
    else           w_new = (w_operand == 2'b00) ? 2'b00 : w_operand - 2'b01;
  end

  // Stage B can only be valid in RUN or FLUSH_WAIT, so it never competes with a sweep.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;
    if (!reset) begin
      if (w_sweep) begin
        tbl_we    = 1'b1;
        tbl_waddr = r_cnt;
        tbl_wdata = INIT_VALUE;
      end else if (r_b_valid) begin
        tbl_we    = 1'b1;
        tbl_waddr = r_b_index;
        tbl_wdata = w_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_b_valid   <= 1'b0;
      r_fwd_valid <= 1'b0;
    end else begin
      r_b_valid   <= w_accept;
      r_fwd_valid <= r_b_valid;
      if (r_b_valid) begin
        r_fwd_index <= r_b_index;
        r_fwd_data  <= w_new;
      end
      case (r_state)
        S_INIT, S_FLUSH: begin
          if (r_cnt == '1) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN:        if (flush_req) r_state <= S_FLUSH_WAIT;
        S_FLUSH_WAIT: r_state <= S_FLUSH;
        default:      r_state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_b_index <= upd_index;
      r_b_taken <= upd_taken;
    end
  end

endmodule

// File: tb/tb_bp_table_sequencer.sv
// Scoreboard bench for bp_table_sequencer (INDEX_BITS=4): expected table writes are
// queued with their cycle number by the stimulus and consumed by a write monitor.
module tb_bp_table_sequencer;

  localparam int IB = 4;
  localparam int N  = 1 << IB;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush_req;
  logic          upd_valid;
  logic [IB-1:0] upd_index;
  logic          upd_taken;
  logic          upd_ready;
  logic [IB-1:0] tbl_raddr;
  logic [1:0]    tbl_rdata;
  logic          tbl_we;
  logic [IB-1:0] tbl_waddr;
  logic [1:0]    tbl_wdata;
  logic          busy;

  bp_table_sequencer #(.INDEX_BITS(IB), .INIT_VALUE(2'b10)) dut (
    .clk(clk), .reset(reset), .flush_req(flush_req),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .tbl_raddr(tbl_raddr), .tbl_rdata(tbl_rdata),
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Table storage: synchronous read, old data on read/write collision.
  logic [1:0] mem [N];
  always @(posedge clk) begin
    if (tbl_we) mem[tbl_waddr] <= tbl_wdata;
    tbl_rdata <= mem[tbl_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic [1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  model_tbl[N];

  always @(negedge clk) begin
    if (tbl_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d addr=%0d data=%0d required=none", cyc, tbl_waddr, tbl_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.addr != tbl_waddr || e.data != tbl_wdata) begin
          errors++;
          $display("FAIL table_write actual cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                   cyc, tbl_waddr, tbl_wdata, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  function automatic int sat(int v, bit t);
    if (t) return (v == 3) ? 3 : v + 1;
    return (v == 0) ? 0 : v - 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  task automatic push_sweep(int start);
    for (int k = 0; k < N; k++) begin
      wr_t e;
      e.cyc = start + k; e.addr = 4'(k); e.data = 2'b10;
      exp_q.push_back(e);
      model_tbl[k] = 2;
    end
  endtask

  // Present an update in the current cycle; when commit=1 its write is expected next cycle.
  task automatic issue(int idx, bit t, bit commit);
    upd_valid = 1'b1;
    upd_index = 4'(idx);
    upd_taken = t;
    if (commit) begin
      wr_t e;
      int  nv;
      nv = sat(model_tbl[idx], t);
      e.cyc = cyc + 1; e.addr = 4'(idx); e.data = 2'(nv);
      exp_q.push_back(e);
      model_tbl[idx] = nv;
    end
  endtask

  // Runs from a RUN cycle t through the flush until RUN is back at t+18.
  task automatic do_flush(bit with_upd, int idx, bit t);
    int t0;
    t0 = cyc;
    chk("flush_ready_before", int'(upd_ready), 1);
    flush_req = 1'b1;
    if (with_upd) issue(idx, t, 1'b1);
    else upd_valid = 1'b0;
    push_sweep(t0 + 2);
    step();
    flush_req = 1'b0;
    upd_valid = 1'b1;
    upd_index = 4'($urandom_range(0, N - 1));
    chk("flush_wait_ready", int'(upd_ready), 0);
    step();
    chk("flush_busy", int'(busy), 1);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int k = 0; k < 20 && cyc < t0 + 17; k++) step();
    chk("flush_end_ready_low", int'(upd_ready), 0);
    step();
    upd_valid = 1'b0;
    chk("flush_ready_back", int'(upd_ready), 1);
    chk("flush_busy_low", int'(busy), 0);
  endtask

  task automatic release_and_init(bit flush_in_init);
    reset = 1'b0;
    push_sweep(cyc);
    upd_valid = 1'b1;
    upd_index = 4'($urandom_range(0, N - 1));
    upd_taken = 1'b1;
    for (int k = 1; k < N; k++) begin
      step();
      flush_req = flush_in_init && (k == 5);
    end
    chk("init_ready_low", int'(upd_ready), 0);
    chk("init_busy_high", int'(busy), 1);
    step();
    flush_req = 1'b0;
    upd_valid = 1'b0;
    chk("init_ready_rise", int'(upd_ready), 1);
    chk("init_busy_fall", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush_req = 1'b0; upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0;
    repeat (3) step();
    chk("reset_ready", int'(upd_ready), 0);
    chk("reset_busy", int'(busy), 1);
    chk("reset_we", int'(tbl_we), 0);
    release_and_init(1'b1);

    for (int i = 0; i < 4; i++) begin issue(3, 1'b1, 1'b1); step(); end
    for (int i = 0; i < 4; i++) begin issue(3, 1'b0, 1'b1); step(); end
    upd_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) issue(5, 1'b1, 1'b1);
      else            issue(6, 1'b0, 1'b1);
      step();
    end
    upd_valid = 1'b0;
    step(); step();
    chk("readback_5", int'(mem[5]), 3);
    chk("readback_6", int'(mem[6]), 0);

    do_flush(1'b1, 2, 1'b1);

    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 39);
      if (r == 0) begin
        do_flush(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else if (r < 30) begin
        chk("run_ready", int'(upd_ready), 1);
        issue($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
        step();
      end else begin
        upd_valid = 1'b0;
        step();
      end
    end
    upd_valid = 1'b0;
    step(); step();

    issue(4, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    upd_valid = 1'b0;
    #1;
    chk("abort_we", int'(tbl_we), 0);
    chk("abort_ready", int'(upd_ready), 0);
    chk("abort_busy", int'(busy), 1);
    step(); step();
    release_and_init(1'b0);

    issue(4, 1'b0, 1'b1);
    step();
    upd_valid = 1'b0;
    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_table_sequencer.md
# bp_table_sequencer

Sequencer and write-port owner for a branch-predictor saturating-counter table (2-bit counters, synchronous read). It initialises the table after reset, re-initialises it on a flush request, and runs the read-modify-write (RMW) update pipeline for resolved branches, with forwarding for back-to-back updates. It sits between the memory-stage branch-resolution logic and the counter-table storage. The predictor's lookup read port is separate from this block and is not part of it.

## Interface

- INDEX_BITS, 8, table index width; the table has 2^INDEX_BITS entries.
- INIT_VALUE, 2'b10, value written to every entry on init and on flush (weakly taken).

- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush_req  in  1  one-cycle request to re-initialise the whole table.
- upd_valid  in  1  a resolved branch update is presented.
- upd_index  in  INDEX_BITS  table entry to update.
- upd_taken  in  1  actual branch outcome (1 = taken).
- upd_ready  out  1  update accepted this cycle when upd_valid && upd_ready.
- tbl_raddr  out  INDEX_BITS  table read address; data is returned the next cycle.
- tbl_rdata  in  2  table read data. A read that collides with a write on the same edge returns the old value.
- tbl_we  out  1  table write enable.
- tbl_waddr  out  INDEX_BITS  table write address.
- tbl_wdata  out  2  table write data.
- busy  out  1  init or flush in progress; the predictor forces "not taken" while busy=1.

## Operation

- States: INIT, RUN, FLUSH_WAIT, FLUSH. Reset puts the block in INIT with the counter at 0.
- INIT and FLUSH:
  - Each cycle: tbl_we=1, tbl_waddr=counter, tbl_wdata=INIT_VALUE; counter increments.
  - When the write to address 2^INDEX_BITS-1 completes, go to RUN and clear the counter.
  - busy=1, upd_ready=0.
- RUN: upd_ready=1 (decoded from state only), busy=0.
- Update pipeline, stage A (accept cycle):
  - tbl_raddr=upd_index, driven combinationally.
  - Register index, taken and a valid bit into stage B.
- Update pipeline, stage B (next cycle):
  - Operand = fwd_data if fwd_valid && fwd_index==B.index; otherwise operand = tbl_rdata.
  - New value = taken ? min(operand+1, 3) : max(operand-1, 0). Saturating, 2-bit, never wraps.
  - Drive tbl_we=1, tbl_waddr=B.index, tbl_wdata=new value.
  - Load fwd_index/fwd_data/fwd_valid with this write. fwd_valid clears on any cycle with no stage-B write.
- flush_req in RUN: go to FLUSH_WAIT.
  - An update accepted in the same cycle is still accepted; it completes its stage-B write during FLUSH_WAIT.
  - FLUSH_WAIT lasts one cycle, then FLUSH starts at counter 0.
- flush_req in INIT, FLUSH_WAIT or FLUSH: ignored, not queued.
- Upd_valid while upd_ready=0: no action. The producer holds the request.
- Reset at any point: abort everything and return to INIT at counter 0. Stage B valid and fwd_valid are cleared; an in-flight update is discarded.
- tbl_raddr is don't-care when no update is accepted. It is driven as 0.

## Timing

- While reset=1: tbl_we=0, upd_ready=0, busy=1, stage B and forwarding invalid.
- Init:
  - The write to address 0 occurs in the first cycle with reset=0.
  - Address k is written in cycle k after reset release.
  - upd_ready=1 and busy=0 from cycle 2^INDEX_BITS.
- Update latency: accepted in cycle t, table written at the end of cycle t+1. One update per cycle sustained.
- Back-to-back updates to the same index (cycles t and t+1): the second update uses the forwarded value, not the stale tbl_rdata.
- Flush sampled in cycle t:
  - upd_ready=0 from t+1.
  - FLUSH_WAIT in t+1; flush write to address 0 in t+2.
  - RUN again in cycle t+2+2^INDEX_BITS.
- Exactly one writer per cycle: the init/flush counter and stage B are never active in the same cycle.

## Test plan

- Reset then release, INDEX_BITS=4: addresses 0..15 are written with 2'b10 in cycles 0..15; upd_ready rises in cycle 16; busy falls in cycle 16.
- Four taken updates to index 3 on consecutive cycles after init: writes 3, 3, 3, 3 (saturation holds). Then four not-taken updates: writes 2, 1, 0, 0.
- Alternating updates to index 5 (taken) and index 6 (not-taken) every cycle: the table reads back 5→3 and 6→0 after enough cycles; no cross-forwarding errors.
- flush_req and upd_valid together in cycle t with index 2 taken:
  - index 2 is written 3 in cycle t+1;
  - FLUSH rewrites 0..15 to 2'b10 from t+2;
  - upd_ready returns in t+18.
- flush_req pulsed during INIT (cycle 5): ignored; RUN is still reached in cycle 16, with no second sweep.
- Reset asserted in the cycle after an update is accepted: no stage-B write occurs; INIT restarts at address 0 in the first cycle after release.
